// File: rtl/dmux4_dispatch_ctrl_pkg.sv
// Shared constants for the 4-way dispatch controller: channel indices, mode
// encoding and the round-robin step.
package dmux4_dispatch_ctrl_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  function automatic logic [1:0] rr_next(input logic [1:0] ptr);
    return ptr + 2'd1;
  endfunction

endpackage

// File: rtl/DMux4Way16.sv
// Data steering demux: routes the input word to the output selected by sel,
// all other outputs are zero.
module DMux4Way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);

  always_comb begin
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    case (sel)
      2'd0:    a = in;
      2'd1:    b = in;
      2'd2:    c = in;
      default: d = in;
    endcase
  end

endmodule

// File: rtl/dispatch_slot.sv
// One output channel: single-entry word buffer with valid flag and a
// wrapping count of words taken by the consumer.
module dispatch_slot
  import dmux4_dispatch_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain = r_valid & i_ready;

  // A load wins over both drain and flush so a word accepted this cycle survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_load)
        r_valid <= 1'b1;
      else if (i_flush || w_drain)
        r_valid <= 1'b0;
      if (i_load)
        r_data <= i_data;
      if (w_drain)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/dmux4_dispatch_ctrl.sv
// Dispatch controller: steers a single valid/ready word stream into four
// one-entry channel buffers, by explicit select or strict round-robin.
module dmux4_dispatch_ctrl
  import dmux4_dispatch_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              flush,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [WIDTH-1:0]  out_c,
  output logic [WIDTH-1:0]  out_d,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [1:0]        rr_ptr,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_c,
  output logic [CNT_W-1:0]  cnt_d
);

  logic [1:0]        r_rr;
  logic [1:0]        w_tgt;
  logic              w_accept;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_valid;
  logic [WIDTH-1:0]  w_steer [NUM_CH];
  logic [WIDTH-1:0]  w_data  [NUM_CH];
  logic [CNT_W-1:0]  w_cnt   [NUM_CH];

  assign w_tgt    = (mode_e'(mode) == MODE_RR) ? r_rr : in_sel;
  assign in_ready = ~w_valid[w_tgt] | out_ready[w_tgt] | flush;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load = '0;
    if (w_accept)
      w_load[w_tgt] = 1'b1;
  end

  // Flush restarts the rotation at channel a, even if a word is accepted alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rr <= CH_A;
    else if (flush)
      r_rr <= CH_A;
    else if (w_accept && mode_e'(mode) == MODE_RR)
      r_rr <= rr_next(r_rr);
  end

  DMux4Way16 #(.WIDTH(WIDTH)) u_steer (
    .in  (in_data),
    .sel (w_tgt),
    .a   (w_steer[CH_A]),
    .b   (w_steer[CH_B]),
    .c   (w_steer[CH_C]),
    .d   (w_steer[CH_D])
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    dispatch_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk     (clk),
      .rst     (reset),
      .i_load  (w_load[g]),
      .i_flush (flush),
      .i_ready (out_ready[g]),
      .i_data  (w_steer[g]),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g]),
      .o_cnt   (w_cnt[g])
    );
  end

  assign out_valid = w_valid;
  assign rr_ptr    = r_rr;
  assign out_a     = w_data[CH_A];
  assign out_b     = w_data[CH_B];
  assign out_c     = w_data[CH_C];
  assign out_d     = w_data[CH_D];
  assign cnt_a     = w_cnt[CH_A];
  assign cnt_b     = w_cnt[CH_B];
  assign cnt_c     = w_cnt[CH_C];
  assign cnt_d     = w_cnt[CH_D];

endmodule

// File: tb/tb_dmux4_dispatch_ctrl.sv
// Bench for dmux4_dispatch_ctrl: per-channel expected-word queues fed at
// accept time, popped by a monitor on every drain, plus directed scenarios.
module tb_dmux4_dispatch_ctrl;

  logic        clk;
  logic        reset;
  logic        mode;
  logic        flush;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_a, out_b, out_c, out_d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;

  dmux4_dispatch_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
    .cnt_d     (cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] outs [4];
  logic [7:0]  cnts [4];
  assign outs[0] = out_a;
  assign outs[1] = out_b;
  assign outs[2] = out_c;
  assign outs[3] = out_d;
  assign cnts[0] = cnt_a;
  assign cnts[1] = cnt_b;
  assign cnts[2] = cnt_c;
  assign cnts[3] = cnt_d;

  // Reference model: words waiting per channel, delivered count, rotation position.
  logic [15:0] exp_q [4][$];
  logic [7:0]  m_cnt [4];
  int          m_rr;
  bit          mon_en;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      m_cnt[i] = 8'd0;
    end
    m_rr = 0;
  endtask

  task automatic monitor_step();
    int  tg;
    bit  er;
    bit  full [4];
    for (int i = 0; i < 4; i++) begin
      full[i] = (exp_q[i].size() != 0);
      chk($sformatf("valid[%0d]", i), {31'd0, out_valid[i]}, {31'd0, full[i]});
      if (full[i])
        chk($sformatf("data[%0d]", i), {16'd0, outs[i]}, {16'd0, exp_q[i][0]});
      chk($sformatf("cnt[%0d]", i), {24'd0, cnts[i]}, {24'd0, m_cnt[i]});
    end
    chk("rr_ptr", {30'd0, rr_ptr}, m_rr);
    tg = mode ? m_rr : int'(in_sel);
    er = !full[tg] || out_ready[tg] || flush;
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    for (int i = 0; i < 4; i++) begin
      if (full[i] && out_ready[i]) begin
        void'(exp_q[i].pop_front());
        m_cnt[i] = m_cnt[i] + 8'd1;
      end
    end
    if (flush)
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    if (in_valid && er)
      exp_q[tg].push_back(in_data);
    if (flush)
      m_rr = 0;
    else if (in_valid && er && mode)
      m_rr = (m_rr + 1) % 4;
  endtask

  always @(negedge clk) begin
    #4;
    if (mon_en) monitor_step();
  end

  task automatic step(input logic m, input logic f, input logic [1:0] s,
                      input logic [15:0] d, input logic v, input logic [3:0] r);
    @(negedge clk);
    mode = m; flush = f; in_sel = s; in_data = d; in_valid = v; out_ready = r;
  endtask

  task automatic idle_inputs();
    mode = 1'b0; flush = 1'b0; in_sel = 2'd0; in_data = 16'd0;
    in_valid = 1'b0; out_ready = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    idle_inputs();
    model_clear();
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    mon_en   = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async out_valid", {28'd0, out_valid}, 32'd0);
    chk("async rr_ptr", {30'd0, rr_ptr}, 32'd0);
    chk("async cnt_a", {24'd0, cnt_a}, 32'd0);
    chk("async cnt_b", {24'd0, cnt_b}, 32'd0);
    model_clear();
    idle_inputs();
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    mon_en = 1'b0;
    reset  = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #4;
    chk("reset out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset rr_ptr", {30'd0, rr_ptr}, 32'd0);
    chk("reset out_a", {16'd0, out_a}, 32'd0);
    chk("reset out_d", {16'd0, out_d}, 32'd0);
    chk("reset cnt_c", {24'd0, cnt_c}, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Explicit select, blocked second word
    step(0, 0, 2'd2, 16'hBEEF, 1, 4'b0000);
    step(0, 0, 2'd2, 16'hCAFE, 1, 4'b0000);
    #4;
    chk("sel out_valid", {28'd0, out_valid}, 32'h4);
    chk("sel out_c", {16'd0, out_c}, 32'hBEEF);
    chk("sel in_ready", {31'd0, in_ready}, 32'd0);
    step(0, 0, 2'd2, 16'hCAFE, 1, 4'b0100);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b1111);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b0000);

    // Round-robin, all consumers ready
    do_reset();
    for (int k = 1; k <= 8; k++) step(1, 0, 2'd0, 16'(k), 1, 4'b1111);
    step(1, 0, 2'd0, 16'h0, 0, 4'b1111);
    step(1, 0, 2'd0, 16'h0, 0, 4'b0000);
    #4;
    chk("rr cnt_a", {24'd0, cnt_a}, 32'd2);
    chk("rr cnt_b", {24'd0, cnt_b}, 32'd2);
    chk("rr cnt_c", {24'd0, cnt_c}, 32'd2);
    chk("rr cnt_d", {24'd0, cnt_d}, 32'd2);
    chk("rr end ptr", {30'd0, rr_ptr}, 32'd0);

    // Round-robin stall on full channel b, then load+drain
    do_reset();
    step(1, 0, 2'd0, 16'h0011, 1, 4'b1111);
    step(0, 0, 2'd1, 16'h0022, 1, 4'b1101);
    step(1, 0, 2'd0, 16'h0033, 1, 4'b1101);
    #4;
    chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall rr_ptr", {30'd0, rr_ptr}, 32'd1);
    step(1, 0, 2'd0, 16'h0033, 1, 4'b1101);
    #4;
    chk("stall hold in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall hold out_b", {16'd0, out_b}, 32'h22);
    step(1, 0, 2'd0, 16'h0033, 1, 4'b1111);
    #4;
    chk("unstall in_ready", {31'd0, in_ready}, 32'd1);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b1101);
    #4;
    chk("ld+dr out_valid", {28'd0, out_valid}, 32'h2);
    chk("ld+dr out_b", {16'd0, out_b}, 32'h33);
    chk("ld+dr cnt_b", {24'd0, cnt_b}, 32'd1);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b1111);

    // Flush with a concurrent accept to d
    do_reset();
    step(1, 0, 2'd0, 16'h00A1, 1, 4'b0000);
    step(0, 0, 2'd2, 16'h00C1, 1, 4'b0000);
    step(0, 1, 2'd3, 16'h00D1, 1, 4'b0000);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b0000);
    #4;
    chk("flush out_valid", {28'd0, out_valid}, 32'h8);
    chk("flush out_d", {16'd0, out_d}, 32'hD1);
    chk("flush rr_ptr", {30'd0, rr_ptr}, 32'd0);
    chk("flush cnt_a", {24'd0, cnt_a}, 32'd0);
    chk("flush cnt_c", {24'd0, cnt_c}, 32'd0);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b1111);

    // Asynchronous reset mid-stream, then restart at a
    do_reset();
    for (int k = 1; k <= 6; k++) step(1, 0, 2'd0, 16'(k), 1, 4'b0011);
    async_reset();
    step(1, 0, 2'd0, 16'h0077, 1, 4'b0000);
    step(1, 0, 2'd0, 16'h0000, 0, 4'b0000);
    #4;
    chk("restart out_valid", {28'd0, out_valid}, 32'h1);
    chk("restart out_a", {16'd0, out_a}, 32'h77);
    chk("restart rr_ptr", {30'd0, rr_ptr}, 32'd1);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b1111);

    // Counter wrap: 256 drains on a
    do_reset();
    for (int k = 0; k < 256; k++) step(0, 0, 2'd0, 16'(k), 1, 4'b0001);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b0001);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b0000);
    #4;
    chk("wrap cnt_a", {24'd0, cnt_a}, 32'd0);
    chk("wrap out_valid", {28'd0, out_valid}, 32'd0);

    // Random traffic
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      logic        f;
      logic [3:0]  r;
      f = ($urandom_range(0, 15) == 0);
      r = f ? 4'b0000 : 4'($urandom);
      step(1'($urandom), f, 2'($urandom), 16'($urandom),
           ($urandom_range(0, 3) != 0), r);
    end
    step(0, 0, 2'd0, 16'h0000, 0, 4'b1111);
    step(0, 0, 2'd0, 16'h0000, 0, 4'b0000);
    @(negedge clk);
    #5;
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
